// File: rtl/tea_pkg.sv
// Shared constants, FSM state type and round helpers for the TEA/XTEA core.
package tea_pkg;

    localparam logic [31:0] DELTA = 32'h9E3779B9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic logic [31:0] init_dec_sum(input int unsigned rounds);
        return DELTA * rounds;
    endfunction

    function automatic logic [31:0] tea_f(
        input logic [31:0] v,
        input logic [31:0] ka,
        input logic [31:0] kb,
        input logic [31:0] s
    );
        return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
    endfunction

    function automatic logic [31:0] xtea_mix(input logic [31:0] v);
        return ((v << 4) ^ (v >> 5)) + v;
    endfunction

    function automatic logic [31:0] key_word(
        input logic [127:0] k,
        input logic [1:0]   idx
    );
        return k[32*idx +: 32];
    endfunction

endpackage

// File: rtl/tea_round.sv
// One combinational cipher round for a single 64-bit lane.
// Define TEA_CIPHER_CORE_XTEA_EN to select the XTEA round instead of TEA.
module tea_round
    import tea_pkg::*;
(
    input  logic         dec_i,
    input  logic [127:0] key_i,
    input  logic [31:0]  sum_i,
    input  logic [63:0]  blk_i,
    output logic [63:0]  blk_o
);

    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] y1;
    logic [31:0] z1;
    logic [31:0] s_nxt;

    always_comb begin
        y     = blk_i[31:0];
        z     = blk_i[63:32];
        y1    = y;
        z1    = z;
        s_nxt = sum_i;
`ifdef TEA_CIPHER_CORE_XTEA_EN
        if (!dec_i) begin
            s_nxt = sum_i + DELTA;
            y1 = y + (xtea_mix(z) ^ (sum_i + key_word(key_i, sum_i[1:0])));
            z1 = z + (xtea_mix(y1) ^ (s_nxt + key_word(key_i, s_nxt[12:11])));
        end else begin
            s_nxt = sum_i - DELTA;
            z1 = z - (xtea_mix(y) ^ (sum_i + key_word(key_i, sum_i[12:11])));
            y1 = y - (xtea_mix(z1) ^ (s_nxt + key_word(key_i, s_nxt[1:0])));
        end
`else
        // Encrypt mixes with the already-advanced sum; decrypt with the current one.
        if (!dec_i) begin
            s_nxt = sum_i + DELTA;
            y1 = y + tea_f(z, key_i[31:0], key_i[63:32], s_nxt);
            z1 = z + tea_f(y1, key_i[95:64], key_i[127:96], s_nxt);
        end else begin
            z1 = z - tea_f(y, key_i[95:64], key_i[127:96], s_nxt);
            y1 = y - tea_f(z1, key_i[31:0], key_i[63:32], s_nxt);
        end
`endif
        blk_o = {z1, y1};
    end

endmodule

// File: rtl/tea_cipher_core.sv
// Multi-lane iterative TEA block cipher core, one round per cycle.
// Define TEA_CIPHER_CORE_XTEA_EN to build the XTEA variant.
module tea_cipher_core
    import tea_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int ROUNDS = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  decrypt,
    input  logic [127:0]          key_in,
    input  logic [64*LANES-1:0]   data_in,
    output logic [64*LANES-1:0]   data_out,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic [6:0] LAST = 7'(ROUNDS - 1);

    state_t              state_q, state_d;
    logic [6:0]          cnt_q, cnt_d;
    logic [31:0]         sum_q, sum_d;
    logic [127:0]        key_q, key_d;
    logic                dec_q, dec_d;
    logic [64*LANES-1:0] blk_q, blk_d;
    logic [64*LANES-1:0] dout_q, dout_d;
    logic [64*LANES-1:0] rnd;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        tea_round u_round (
            .dec_i (dec_q),
            .key_i (key_q),
            .sum_i (sum_q),
            .blk_i (blk_q[64*l +: 64]),
            .blk_o (rnd[64*l +: 64])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        key_d   = key_q;
        dec_d   = dec_q;
        blk_d   = blk_q;
        dout_d  = dout_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    blk_d   = data_in;
                    key_d   = key_in;
                    dec_d   = decrypt;
                    cnt_d   = '0;
                    sum_d   = decrypt ? init_dec_sum(ROUNDS) : '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                blk_d = rnd;
                sum_d = dec_q ? sum_q - DELTA : sum_q + DELTA;
                cnt_d = cnt_q + 7'd1;
                // Output register only moves on the final round.
                if (cnt_q == LAST) begin
                    dout_d  = rnd;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sum_q   <= '0;
            key_q   <= '0;
            dec_q   <= 1'b0;
            blk_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            key_q   <= key_d;
            dec_q   <= dec_d;
            blk_q   <= blk_d;
            dout_q  <= dout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign data_out  = dout_q;

endmodule

// File: tb/tb_tea_cipher_core.sv
// Scoreboarded directed bench for tea_cipher_core across three LANES/ROUNDS builds.
module tb_tea_cipher_core;

    localparam logic [31:0] D = 32'h9E3779B9;

    logic         clk = 1'b0;
    logic         rst;
    logic         dec;
    logic         ordy;
    logic [127:0] key;
    logic [511:0] din;
    logic [2:0]   iv;
    logic [2:0]   ir;
    logic [2:0]   ov;
    logic [127:0] do0;
    logic [63:0]  do1;
    logic [511:0] do2;

    int errs = 0;
    int checks = 0;
    logic [511:0] exp_q[$];

    always #5 clk = ~clk;

    tea_cipher_core #(.LANES(2), .ROUNDS(32)) u0 (
        .clock(clk), .reset(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .decrypt(dec), .key_in(key), .data_in(din[127:0]),
        .data_out(do0), .out_valid(ov[0]), .out_ready(ordy)
    );

    tea_cipher_core #(.LANES(1), .ROUNDS(1)) u1 (
        .clock(clk), .reset(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .decrypt(dec), .key_in(key), .data_in(din[63:0]),
        .data_out(do1), .out_valid(ov[1]), .out_ready(ordy)
    );

    tea_cipher_core #(.LANES(8), .ROUNDS(64)) u2 (
        .clock(clk), .reset(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .decrypt(dec), .key_in(key), .data_in(din),
        .data_out(do2), .out_valid(ov[2]), .out_ready(ordy)
    );

    function automatic int lanes_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 8;
    endfunction

    function automatic int rounds_of(input int i);
        return (i == 0) ? 32 : (i == 1) ? 1 : 64;
    endfunction

    function automatic logic [511:0] dout(input int i);
        logic [511:0] r;
        r = '0;
        case (i)
            0: r[127:0] = do0;
            1: r[63:0]  = do1;
            default: r  = do2;
        endcase
        return r;
    endfunction

    function automatic logic [511:0] lane_mask(input int i);
        logic [511:0] m;
        m = '0;
        for (int b = 0; b < 64 * lanes_of(i); b++) m[b] = 1'b1;
        return m;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int w = 0; w < 16; w++) r[32*w +: 32] = $urandom;
        return r;
    endfunction

    // Reference cipher written straight from the algorithm definition.
    function automatic logic [63:0] model(input bit d, input logic [127:0] k,
                                          input logic [63:0] b, input int n);
        logic [31:0] y, z, s;
        logic [31:0] kw[4];
        for (int w = 0; w < 4; w++) kw[w] = k[32*w +: 32];
        y = b[31:0];
        z = b[63:32];
        s = d ? D * 32'(n) : 32'd0;
        for (int r = 0; r < n; r++) begin
`ifdef TEA_CIPHER_CORE_XTEA_EN
            if (!d) begin
                y = y + ((((z << 4) ^ (z >> 5)) + z) ^ (s + kw[s[1:0]]));
                s = s + D;
                z = z + ((((y << 4) ^ (y >> 5)) + y) ^ (s + kw[s[12:11]]));
            end else begin
                z = z - ((((y << 4) ^ (y >> 5)) + y) ^ (s + kw[s[12:11]]));
                s = s - D;
                y = y - ((((z << 4) ^ (z >> 5)) + z) ^ (s + kw[s[1:0]]));
            end
`else
            if (!d) begin
                s = s + D;
                y = y + (((z << 4) + kw[0]) ^ (z + s) ^ ((z >> 5) + kw[1]));
                z = z + (((y << 4) + kw[2]) ^ (y + s) ^ ((y >> 5) + kw[3]));
            end else begin
                z = z - (((y << 4) + kw[2]) ^ (y + s) ^ ((y >> 5) + kw[3]));
                y = y - (((z << 4) + kw[0]) ^ (z + s) ^ ((z >> 5) + kw[1]));
                s = s - D;
            end
`endif
        end
        return {z, y};
    endfunction

    task automatic check(input string tag, input logic [511:0] obs,
                         input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input int i, input bit d, input logic [127:0] k,
                       input logic [511:0] data, input int hold,
                       output logic [511:0] res);
        logic [511:0] e;
        logic [511:0] held;
        int cyc;
        e = '0;
        for (int l = 0; l < lanes_of(i); l++)
            e[64*l +: 64] = model(d, k, data[64*l +: 64], rounds_of(i));
        exp_q.push_back(e);
        @(negedge clk);
        dec = d;
        key = k;
        din = data;
        iv[i] = 1'b1;
        check("in_ready_idle", 512'(ir[i]), 512'd1);
        @(posedge clk);
        #1;
        iv[i] = 1'b0;
        dec = ~d;
        key = ~k;
        din = ~data;
        cyc = 1;
        @(negedge clk);
        while (!ov[i] && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", 512'(cyc), 512'(rounds_of(i) + 1));
        held = dout(i);
        check("data_out", held & lane_mask(i), exp_q.pop_front());
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            iv[i] = (h == 3);
            din = rnd512();
            @(negedge clk);
            check("hold_valid", 512'(ov[i]), 512'd1);
            check("hold_ready", 512'(ir[i]), 512'd0);
            check("hold_data", dout(i), held);
        end
        @(posedge clk);
        #1;
        iv[i] = 1'b0;
        ordy = 1'b1;
        @(posedge clk);
        #1;
        ordy = 1'b0;
        @(negedge clk);
        check("release_ready", 512'(ir[i]), 512'd1);
        check("release_valid", 512'(ov[i]), 512'd0);
        check("retain_data", dout(i), held);
        res = held;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [511:0] r, r2, pt, kat;
        logic [127:0] k;
        rst = 1'b1;
        iv = '0;
        ordy = 1'b0;
        dec = 1'b0;
        key = '0;
        din = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 512'(ir), 512'd7);
        check("reset_valid", 512'(ov), 512'd0);
        check("reset_data", dout(0) | dout(2), 512'd0);
        rst = 1'b0;

        kat = '0;
`ifdef TEA_CIPHER_CORE_XTEA_EN
        kat[127:0] = {32'hF7131ED9, 32'hDEE9D4D8, 32'hF7131ED9, 32'hDEE9D4D8};
`else
        kat[127:0] = {32'h94BAA940, 32'h41EA3A0A, 32'h94BAA940, 32'h41EA3A0A};
`endif
        run(0, 1'b0, '0, '0, 10, r);
        check("kat_encrypt", r, kat);
        run(0, 1'b1, '0, r, 0, r2);
        check("kat_decrypt", r2, 512'd0);

        @(negedge clk);
        din = rnd512();
        key = rnd512()[127:0];
        dec = 1'b0;
        iv[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        iv[0] = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        iv[0] = 1'b0;
        @(negedge clk);
        check("abort_ready", 512'(ir[0]), 512'd1);
        check("abort_valid", 512'(ov[0]), 512'd0);
        check("abort_data", dout(0), 512'd0);
        repeat (40) @(negedge clk);
        check("abort_quiet", 512'({ir[0], ov[0]}), 512'd2);

        k = rnd512()[127:0];
        pt = rnd512();
        run(0, 1'b0, k, pt, 0, r);

        for (int i = 1; i < 3; i++) begin
            for (int t = 0; t < 2; t++) begin
                k = rnd512()[127:0];
                pt = rnd512() & lane_mask(i);
                run(i, 1'b0, k, pt, 0, r);
                run(i, 1'b1, k, r, 0, r2);
                check("round_trip", r2, pt);
            end
        end

        check("scoreboard_empty", 512'(exp_q.size()), 512'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/tea_cipher_core.md
TEA_CIPHER_CORE -- requirements
Module: tea_cipher_core

Interface
REQ-001 Parameter LANES, 2, number of independent 64-bit blocks processed in parallel (1..8).
REQ-002 Parameter ROUNDS, 32, cipher cycles per block (1..64).
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  data_in/key_in/decrypt valid.
REQ-006 in_ready  output  1  core can accept a block set.
REQ-007 decrypt  input  1  0 = encrypt, 1 = decrypt; sampled on accept.
REQ-008 key_in  input  128  key; k0=[31:0], k1=[63:32], k2=[95:64], k3=[127:96]; sampled on accept.
REQ-009 data_in  input  64*LANES  lane n: y=[64n+31:64n], z=[64n+63:64n+32].
REQ-010 data_out  output  64*LANES  result, same lane/word layout as data_in.
REQ-011 out_valid  output  1  data_out holds a completed result.
REQ-012 out_ready  input  1  consumer accepts data_out.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, HOLD; in_ready = (state==IDLE), out_valid = (state==HOLD).
REQ-014 IDLE: on in_valid&&in_ready, latch data, key, and mode; clear round counter; load sum (0 for encrypt, DELTA*ROUNDS mod 2^32 for decrypt); go to RUN.
REQ-015 RUN: one full round per cycle on all lanes; after exactly ROUNDS RUN cycles go to HOLD; out_valid first high ROUNDS+1 cycles after the accept edge.
REQ-016 Encrypt round: sum+=DELTA; y+=((z<<4)+k0)^(z+sum)^((z>>5)+k1); z+=((y'<<4)+k2)^(y'+sum)^((y'>>5)+k3), where y' is the updated y and sum is the updated sum, all in the same cycle.
REQ-017 Decrypt round: z-=((y<<4)+k2)^(y+sum)^((y>>5)+k3); y-=((z'<<4)+k0)^(z'+sum)^((z'>>5)+k1), where z' is the updated z; then sum-=DELTA.
REQ-018 All arithmetic SHALL be modulo 2^32; >> is logical; DELTA=32'h9E3779B9.
REQ-019 HOLD: data_out stable; on out_ready go to IDLE in the same edge; in_ready stays low until IDLE is reached (no same-cycle turnaround).
REQ-020 in_valid while busy SHALL be ignored (no latch, no error); input changes after accept SHALL NOT affect the result.
REQ-021 The round counter SHALL be wide enough for ROUNDS=64 without wrap; ROUNDS=1 SHALL yield exactly one RUN cycle.
REQ-022 data_out SHALL retain the last result after leaving HOLD until the next HOLD.

Reset
REQ-023 Reset SHALL force IDLE, in_ready=1 in the following cycle, out_valid=0, data_out=0, counter=0, sum=0, latched key/data=0.
REQ-024 Reset during RUN or HOLD SHALL abort the operation with no output and no partial data_out update; reset overrides simultaneous in_valid.

Configuration
REQ-025 Macro TEA_CIPHER_CORE_XTEA_EN defined: the round SHALL be XTEA (encrypt: y+=(((z<<4)^(z>>5))+z)^(sum+k[sum&3]); sum+=DELTA; z+=(((y'<<4)^(y'>>5))+y')^(sum+k[(sum>>11)&3]); decrypt is the exact inverse). The macro undefined: TEA per REQ-016/017. Ports, latency, and handshake SHALL be identical in both builds.

Structure
REQ-026 Package tea_pkg SHALL hold DELTA, the FSM state typedef, and a function that returns the initial decrypt sum for a given ROUNDS.
REQ-027 Sub-module tea_round (combinational, one lane, one round, encrypt/decrypt select) SHALL be instantiated LANES times.

Verification
REQ-028 TEA, LANES=2, key=0, data=0, encrypt -> each lane y=32'h41EA3A0A, z=32'h94BAA940; out_valid at cycle 33 after accept.
REQ-029 Decrypt of the REQ-028 output with key=0 -> data_out=0 on both lanes.
REQ-030 XTEA build, key=0, data=0, encrypt -> each lane y=32'hDEE9D4D8, z=32'hF7131ED9.
REQ-031 Hold out_ready=0 for 10 cycles in HOLD -> out_valid and data_out stable; in_ready=0; a pulsed in_valid is ignored.
REQ-032 Assert reset at RUN round 15 -> next cycle in_ready=1, out_valid=0, data_out=0; a new block then completes normally.
REQ-033 ROUNDS=1 and ROUNDS=64 encrypt/decrypt round-trip with random key/data on LANES=1 and LANES=8 -> decrypted output equals the original plaintext.
